// File: rtl/grn_rd_sched_if.sv
// grn_rd_sched_if: control, read-channel and status-write bundle.
// slave = scheduler side, master = control/fabric side.
interface grn_rd_sched_if #(
    parameter int ADDR_W = 42
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       num_lines;
    logic [ADDR_W-1:0] dsm_base;
    logic              c0_almfull;
    logic              c1_almfull;
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [15:0]       rd_req_tag;
    logic              rd_rsp_valid;
    logic              dsm_wr_valid;
    logic [ADDR_W-1:0] dsm_wr_addr;
    logic [63:0]       dsm_wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, base_addr, num_lines, dsm_base,
        output c0_almfull, c1_almfull, rd_rsp_valid,
        input  rd_req_valid, rd_req_addr, rd_req_tag,
        input  dsm_wr_valid, dsm_wr_addr, dsm_wr_data,
        input  busy, done, err
    );

    modport slave (
        input  start, base_addr, num_lines, dsm_base,
        input  c0_almfull, c1_almfull, rd_rsp_valid,
        output rd_req_valid, rd_req_addr, rd_req_tag,
        output dsm_wr_valid, dsm_wr_addr, dsm_wr_data,
        output busy, done, err
    );
endinterface

// File: rtl/grn_rd_sched.sv
// grn_rd_sched: issues num_lines reads from base_addr with an outstanding
// cap, drains responses, writes a status line, pulses done.
// Ports: clk, reset (sync, active high), bus (grn_rd_sched_if.slave).
// Optional GRN_RD_SCHED_PERF_EN: busy-cycle count in dsm_wr_data[63:32].
module grn_rd_sched #(
    parameter int MAX_OUTSTANDING = 64,
    parameter int ADDR_W          = 42
) (
    input logic           clk,
    input logic           reset,
    grn_rd_sched_if.slave bus
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OW-1:0] MAX_V = OW'(MAX_OUTSTANDING);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_REPORT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] dsm_q, dsm_d;
    logic [31:0]       num_q, num_d;
    logic [31:0]       idx_q, idx_d;
    logic [31:0]       rcv_q, rcv_d;
    logic [OW-1:0]     out_q, out_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       tag_q, tag_d;
    logic              wr_q, wr_d;
    logic [63:0]       data_q, data_d;
    logic              busy_q;
    logic              done_q, done_d;
    logic [31:0]       perf;
    logic              issue;
    logic              rsp_ok;

`ifdef GRN_RD_SCHED_PERF_EN
    logic [31:0] cyc_q, cyc_d;

    // Counts cycles spent in ISSUE/DRAIN; frozen once REPORT is entered.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE && bus.start) begin
            cyc_d = '0;
        end else if ((state_q == S_ISSUE || state_q == S_DRAIN)
                     && cyc_q != '1) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end

    assign perf = cyc_q;
`else
    assign perf = '0;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        dsm_d   = dsm_q;
        num_d   = num_q;
        idx_d   = idx_q;
        rcv_d   = rcv_q;
        err_d   = err_q;
        req_d   = 1'b0;
        addr_d  = addr_q;
        tag_d   = tag_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        issue   = 1'b0;

        // A response with nothing in flight is flagged and otherwise ignored.
        rsp_ok = bus.rd_rsp_valid && (out_q != '0);
        if (bus.rd_rsp_valid && out_q == '0) err_d = 1'b1;
        if (rsp_ok) rcv_d = rcv_q + 32'd1;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    num_d   = bus.num_lines;
                    dsm_d   = bus.dsm_base;
                    idx_d   = '0;
                    rcv_d   = '0;
                    state_d = (bus.num_lines != '0) ? S_ISSUE : S_REPORT;
                end
            end
            S_ISSUE: begin
                if (!bus.c0_almfull && out_q < MAX_V) begin
                    issue  = 1'b1;
                    req_d  = 1'b1;
                    addr_d = base_q + ADDR_W'(idx_q);
                    tag_d  = idx_q[15:0];
                    idx_d  = idx_q + 32'd1;
                    if (idx_q == num_q - 32'd1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_q == '0 && rcv_q == num_q) state_d = S_REPORT;
            end
            S_REPORT: begin
                if (!bus.c1_almfull) begin
                    wr_d    = 1'b1;
                    data_d  = {perf, rcv_q};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        unique case ({issue, rsp_ok})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            dsm_q   <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            rcv_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            tag_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            dsm_q   <= dsm_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            rcv_q   <= rcv_d;
            out_q   <= out_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
        end
    end

    assign bus.rd_req_valid = req_q;
    assign bus.rd_req_addr  = addr_q;
    assign bus.rd_req_tag   = tag_q;
    assign bus.dsm_wr_valid = wr_q;
    assign bus.dsm_wr_addr  = dsm_q;
    assign bus.dsm_wr_data  = data_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_grn_rd_sched.sv
// tb_grn_rd_sched: randomized bench for grn_rd_sched with a
// transaction-level model of issue order, in-flight cap and status.
module tb_grn_rd_sched;
    localparam int AW   = 42;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    grn_rd_sched_if #(.ADDR_W(AW)) bus ();

    grn_rd_sched #(
        .MAX_OUTSTANDING(MAXO),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] obs_addr[$];
    logic [15:0]   obs_tag[$];
    int            dsm_cnt = 0;
    logic [63:0]   dsm_data = '0;
    logic [AW-1:0] dsm_addr = '0;
    int            done_cnt = 0;
    int            lim_viol = 0;
    int            c0_viol = 0;
    int            c1_viol = 0;
    int            tb_out = 0;
    logic          c0_prev = 1'b0;
    logic          c1_prev = 1'b0;

    bit rsp_en = 1'b0;
    int rsp_pct = 100;
    int extra_req = 0;
    int extra_done = 0;

    // Observation: in-flight model is issued minus accepted responses,
    // cleared on reset; stray responses do not reduce it.
    always @(negedge clk) begin
        if (bus.rd_req_valid) begin
            if (tb_out >= MAXO) lim_viol++;
            if (c0_prev) c0_viol++;
            obs_addr.push_back(bus.rd_req_addr);
            obs_tag.push_back(bus.rd_req_tag);
        end
        if (bus.dsm_wr_valid) begin
            if (c1_prev) c1_viol++;
            dsm_cnt++;
            dsm_data = bus.dsm_wr_data;
            dsm_addr = bus.dsm_wr_addr;
        end
        if (bus.done) done_cnt++;
        if (reset) begin
            tb_out = 0;
        end else begin
            if (bus.rd_rsp_valid && tb_out > 0) tb_out--;
            if (bus.rd_req_valid) tb_out++;
        end
        c0_prev = bus.c0_almfull;
        c1_prev = bus.c1_almfull;
    end

    // Responder: only answers requests already seen, unless forced.
    initial begin
        bus.rd_rsp_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rd_rsp_valid = 1'b0;
            if (!reset) begin
                if (extra_req > extra_done) begin
                    bus.rd_rsp_valid = 1'b1;
                    extra_done++;
                end else if (rsp_en && tb_out > 0
                             && $urandom_range(99) < rsp_pct) begin
                    bus.rd_rsp_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] b,
                               input logic [31:0] n,
                               input logic [AW-1:0] d);
        bus.base_addr = b;
        bus.num_lines = n;
        bus.dsm_base  = d;
        bus.start     = 1'b1;
        cyc(1);
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int k0;
        int n;
        k0 = done_cnt;
        n = 0;
        while (done_cnt == k0 && n < budget) begin
            cyc(1);
            n++;
        end
        ok = (done_cnt != k0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(3);
        @(negedge clk);
        checks++;
        if ({bus.rd_req_valid, bus.dsm_wr_valid, bus.busy,
             bus.done, bus.err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.rd_req_valid, bus.dsm_wr_valid, bus.busy,
                      bus.done, bus.err});
        end
        checks++;
        if (bus.rd_req_addr !== '0 || bus.rd_req_tag !== '0
            || bus.dsm_wr_data !== '0 || bus.dsm_wr_addr !== '0) begin
            errors++;
            $display("FAIL reset_buses: got %0h/%0h/%0h/%0h expected 0",
                     bus.rd_req_addr, bus.rd_req_tag,
                     bus.dsm_wr_data, bus.dsm_wr_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_basic;
        int a0, d0, k0, l0;
        bit ok;
        a0 = obs_addr.size();
        d0 = dsm_cnt;
        k0 = done_cnt;
        l0 = lim_viol;
        rsp_en = 1'b1;
        rsp_pct = 100;
        pulse_start(42'h100, 32'd4, 42'h2A0);
        wait_done(200, ok);
        cyc(3);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done: got timeout expected done");
        end
        checks++;
        if (obs_addr.size() - a0 != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 4",
                     obs_addr.size() - a0);
        end
        for (int i = 0; i < 4; i++) begin
            if (a0 + i < obs_addr.size()) begin
                checks++;
                if (obs_addr[a0+i] !== AW'(42'h100 + i)
                    || obs_tag[a0+i] !== 16'(i)) begin
                    errors++;
                    $display("FAIL basic_req%0d: got %0h/%0h expected %0h/%0h",
                             i, obs_addr[a0+i], obs_tag[a0+i],
                             42'h100 + i, i);
                end
            end
        end
        checks++;
        if (dsm_cnt - d0 != 1 || dsm_data[31:0] !== 32'd4
            || dsm_addr !== 42'h2A0) begin
            errors++;
            $display("FAIL basic_dsm: got %0d/%0h/%0h expected 1/4/2a0",
                     dsm_cnt - d0, dsm_data[31:0], dsm_addr);
        end
        checks++;
`ifdef GRN_RD_SCHED_PERF_EN
        if (dsm_data[63:32] < 32'd4) begin
            errors++;
            $display("FAIL basic_perf: got %0d expected >=4",
                     dsm_data[63:32]);
        end
`else
        if (dsm_data[63:32] !== 32'd0) begin
            errors++;
            $display("FAIL basic_perf: got %0h expected 0",
                     dsm_data[63:32]);
        end
`endif
        checks++;
        if (done_cnt - k0 != 1 || bus.err !== 1'b0
            || lim_viol != l0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: got done=%0d err=%b lim=%0d busy=%b expected 1/0/0/0",
                     done_cnt - k0, bus.err, lim_viol - l0, bus.busy);
        end
    endtask

    task automatic test_zero;
        int a0, d0, k0;
        bit ok;
        a0 = obs_addr.size();
        d0 = dsm_cnt;
        k0 = done_cnt;
        pulse_start(42'h777, 32'd0, 42'h123);
        wait_done(50, ok);
        cyc(3);
        checks++;
        if (!ok || obs_addr.size() != a0) begin
            errors++;
            $display("FAIL zero_req: got ok=%b reqs=%0d expected 1/0",
                     ok, obs_addr.size() - a0);
        end
        checks++;
        if (dsm_cnt - d0 != 1 || dsm_data !== 64'd0
            || done_cnt - k0 != 1) begin
            errors++;
            $display("FAIL zero_dsm: got wr=%0d data=%0h done=%0d expected 1/0/1",
                     dsm_cnt - d0, dsm_data, done_cnt - k0);
        end
    endtask

    task automatic test_max;
        int a0, l0;
        bit ok;
        logic [AW-1:0] b;
        logic [63:0] r;
        r = {$urandom, $urandom};
        b = r[AW-1:0];
        a0 = obs_addr.size();
        l0 = lim_viol;
        rsp_en = 1'b0;
        pulse_start(b, 32'd10, 42'h40);
        cyc(20);
        checks++;
        if (obs_addr.size() - a0 != MAXO || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL max_cap: got %0d busy=%b expected %0d/1",
                     obs_addr.size() - a0, bus.busy, MAXO);
        end
        for (int k = 1; k <= 3; k++) begin
            extra_req++;
            cyc(8);
            checks++;
            if (obs_addr.size() - a0 != MAXO + k) begin
                errors++;
                $display("FAIL max_step%0d: got %0d expected %0d",
                         k, obs_addr.size() - a0, MAXO + k);
            end
        end
        rsp_en = 1'b1;
        rsp_pct = 100;
        wait_done(300, ok);
        cyc(2);
        checks++;
        if (!ok || obs_addr.size() - a0 != 10 || dsm_data[31:0] !== 32'd10
            || lim_viol != l0) begin
            errors++;
            $display("FAIL max_end: got ok=%b n=%0d data=%0d lim=%0d expected 1/10/10/0",
                     ok, obs_addr.size() - a0, dsm_data[31:0], lim_viol - l0);
        end
        for (int i = 0; i < 10; i++) begin
            if (a0 + i < obs_addr.size()) begin
                checks++;
                if (obs_addr[a0+i] !== b + AW'(i)) begin
                    errors++;
                    $display("FAIL max_addr%0d: got %0h expected %0h",
                             i, obs_addr[a0+i], b + AW'(i));
                end
            end
        end
    endtask

    task automatic test_almfull;
        int a0, d0, c0v, c1v, m, n;
        bit ok;
        a0 = obs_addr.size();
        d0 = dsm_cnt;
        c0v = c0_viol;
        c1v = c1_viol;
        rsp_en = 1'b1;
        rsp_pct = 100;
        bus.c1_almfull = 1'b1;
        pulse_start(42'h5000, 32'd8, 42'h99);
        n = 0;
        while (obs_addr.size() - a0 < 2 && n < 100) begin
            cyc(1);
            n++;
        end
        bus.c0_almfull = 1'b1;
        cyc(1);
        m = obs_addr.size();
        cyc(4);
        checks++;
        if (obs_addr.size() != m) begin
            errors++;
            $display("FAIL c0_stall: got %0d new expected 0",
                     obs_addr.size() - m);
        end
        bus.c0_almfull = 1'b0;
        n = 0;
        while (obs_addr.size() - a0 < 8 && n < 200) begin
            cyc(1);
            n++;
        end
        cyc(15);
        checks++;
        if (obs_addr.size() - a0 != 8 || dsm_cnt != d0
            || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL c1_stall: got n=%0d wr=%0d busy=%b expected 8/0/1",
                     obs_addr.size() - a0, dsm_cnt - d0, bus.busy);
        end
        bus.c1_almfull = 1'b0;
        wait_done(50, ok);
        cyc(2);
        checks++;
        if (!ok || dsm_cnt - d0 != 1 || dsm_data[31:0] !== 32'd8
            || c0_viol != c0v || c1_viol != c1v) begin
            errors++;
            $display("FAIL almfull_end: got ok=%b wr=%0d data=%0d v=%0d/%0d expected 1/1/8/0/0",
                     ok, dsm_cnt - d0, dsm_data[31:0],
                     c0_viol - c0v, c1_viol - c1v);
        end
    endtask

    task automatic test_wrap;
        int a0;
        bit ok;
        a0 = obs_addr.size();
        pulse_start(42'h3FF_FFFF_FFFF, 32'd2, 42'h7);
        wait_done(100, ok);
        cyc(2);
        checks++;
        if (!ok || obs_addr.size() - a0 != 2) begin
            errors++;
            $display("FAIL wrap_count: got ok=%b n=%0d expected 1/2",
                     ok, obs_addr.size() - a0);
        end else begin
            checks++;
            if (obs_addr[a0] !== 42'h3FF_FFFF_FFFF
                || obs_addr[a0+1] !== 42'h0) begin
                errors++;
                $display("FAIL wrap_addr: got %0h,%0h expected 3ffffffffff,0",
                         obs_addr[a0], obs_addr[a0+1]);
            end
        end
    endtask

    task automatic test_random;
        int a0, d0, k0, v0, num, n;
        bit ok;
        logic [63:0] r;
        logic [AW-1:0] b, d;
        for (int j = 0; j < 5; j++) begin
            r = {$urandom, $urandom};
            b = r[AW-1:0];
            r = {$urandom, $urandom};
            d = r[AW-1:0];
            num = $urandom_range(24, 1);
            rsp_pct = $urandom_range(100, 20);
            rsp_en = 1'b1;
            a0 = obs_addr.size();
            d0 = dsm_cnt;
            k0 = done_cnt;
            v0 = lim_viol + c0_viol + c1_viol;
            pulse_start(b, num, d);
            n = 0;
            while (done_cnt == k0 && n < 2000) begin
                bus.c0_almfull = ($urandom_range(3) == 0);
                bus.c1_almfull = ($urandom_range(3) == 0);
                bus.start = (n == 3 && bus.busy);
                bus.base_addr = ~b;
                bus.num_lines = 32'd3;
                cyc(1);
                n++;
            end
            bus.start = 1'b0;
            bus.c0_almfull = 1'b0;
            bus.c1_almfull = 1'b0;
            ok = (done_cnt != k0);
            cyc(3);
            checks++;
            if (!ok || obs_addr.size() - a0 != num) begin
                errors++;
                $display("FAIL rand%0d_count: got ok=%b n=%0d expected 1/%0d",
                         j, ok, obs_addr.size() - a0, num);
            end
            for (int i = 0; i < num; i++) begin
                if (a0 + i < obs_addr.size()) begin
                    checks++;
                    if (obs_addr[a0+i] !== b + AW'(i)
                        || obs_tag[a0+i] !== 16'(i)) begin
                        errors++;
                        $display("FAIL rand%0d_req%0d: got %0h/%0h expected %0h/%0h",
                                 j, i, obs_addr[a0+i], obs_tag[a0+i],
                                 b + AW'(i), i);
                    end
                end
            end
            checks++;
            if (dsm_cnt - d0 != 1 || dsm_data[31:0] !== 32'(num)
                || dsm_addr !== d || done_cnt - k0 != 1
                || lim_viol + c0_viol + c1_viol != v0
                || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_end: got wr=%0d data=%0d addr=%0h done=%0d v=%0d err=%b expected 1/%0d/%0h/1/0/0",
                         j, dsm_cnt - d0, dsm_data[31:0], dsm_addr,
                         done_cnt - k0, lim_viol + c0_viol + c1_viol - v0,
                         bus.err, num, d);
            end
        end
    endtask

    task automatic test_reset_mid;
        int a0, d0, k0;
        a0 = obs_addr.size();
        d0 = dsm_cnt;
        k0 = done_cnt;
        rsp_en = 1'b0;
        pulse_start(42'hABC0, 32'd3, 42'h11);
        cyc(12);
        checks++;
        if (obs_addr.size() - a0 != 3 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_drain: got n=%0d busy=%b expected 3/1",
                     obs_addr.size() - a0, bus.busy);
        end
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        extra_req += 2;
        cyc(12);
        checks++;
        if (bus.busy !== 1'b0 || done_cnt != k0 || dsm_cnt != d0
            || obs_addr.size() - a0 != 3) begin
            errors++;
            $display("FAIL mid_abandon: got busy=%b done=%0d wr=%0d n=%0d expected 0/0/0/3",
                     bus.busy, done_cnt - k0, dsm_cnt - d0,
                     obs_addr.size() - a0);
        end
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL mid_err: got %b expected 1", bus.err);
        end
        cyc(5);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", bus.err);
        end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", bus.err);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.num_lines  = '0;
        bus.dsm_base   = '0;
        bus.c0_almfull = 1'b0;
        bus.c1_almfull = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_almfull();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
